// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle add/sub, 16-iteration shift-add multiply and restoring divide.
// Define ALU_HI_RESULT_EN to return the product high word / remainder on result_hi.
module alu_exec_unit #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        op_opcode,
   input  logic [DATA_W-1:0] rs1_reg_val,
   input  logic [DATA_W-1:0] rs2_reg_val,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] result_hi,
   output logic              carry,
   output logic              div_by_zero
);
`ifdef ALU_HI_RESULT_EN
   localparam int AW = 2 * DATA_W;
`else
   localparam int AW = DATA_W;
`endif
   localparam logic [4:0] LAST_ITER = 5'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [AW-1:0]     mcand_q, mcand_d, acc_q, acc_d;
   logic [DATA_W-1:0] mplier_q, mplier_d, rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
   logic [DATA_W-1:0] result_q, result_d, result_hi_q, result_hi_d;
   logic              carry_q, carry_d, dbz_q, dbz_d;

   logic              accept_s, div_ok_s;
   logic [AW-1:0]     mul_sum_s;
   logic [DATA_W:0]   add_s, sub_s, div_shift_s, div_trial_s;
   logic [DATA_W-1:0] rem_next_s, quo_next_s, dz_hi_s, mul_hi_s, div_hi_s;

   assign in_ready = ~rst & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
   assign accept_s = in_valid & in_ready;

   assign add_s = {1'b0, rs1_reg_val} + {1'b0, rs2_reg_val};
   assign sub_s = {1'b0, rs1_reg_val} - {1'b0, rs2_reg_val};

   assign mul_sum_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   // Restoring step: the trial difference is negative exactly when its top bit is set.
   assign div_shift_s = {rem_q, quo_q[DATA_W-1]};
   assign div_trial_s = div_shift_s - {1'b0, dvsr_q};
   assign div_ok_s    = ~div_trial_s[DATA_W];
   assign rem_next_s  = div_ok_s ? div_trial_s[DATA_W-1:0] : div_shift_s[DATA_W-1:0];
   assign quo_next_s  = {quo_q[DATA_W-2:0], div_ok_s};

`ifdef ALU_HI_RESULT_EN
   assign dz_hi_s  = rs1_reg_val;
   assign mul_hi_s = mul_sum_s[AW-1 -: DATA_W];
   assign div_hi_s = rem_next_s;
`else
   assign dz_hi_s  = {DATA_W{1'b0}};
   assign mul_hi_s = {DATA_W{1'b0}};
   assign div_hi_s = {DATA_W{1'b0}};
`endif

   // Next-state, datapath and output-register update; a new operation always wins.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      acc_d       = acc_q;
      mplier_d    = mplier_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvsr_d      = dvsr_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      carry_d     = carry_q;
      dbz_d       = dbz_q;
      if (accept_s) begin
         case (op_opcode)
            2'd0: begin
               result_d    = add_s[DATA_W-1:0];
               carry_d     = add_s[DATA_W];
               result_hi_d = {DATA_W{1'b0}};
               dbz_d       = 1'b0;
               state_d     = S_DONE;
            end
            2'd1: begin
               result_d    = sub_s[DATA_W-1:0];
               carry_d     = sub_s[DATA_W];
               result_hi_d = {DATA_W{1'b0}};
               dbz_d       = 1'b0;
               state_d     = S_DONE;
            end
            2'd2: begin
               mcand_d  = AW'(rs1_reg_val);
               mplier_d = rs2_reg_val;
               acc_d    = {AW{1'b0}};
               cnt_d    = 5'd0;
               state_d  = S_MUL;
            end
            2'd3: begin
               if (rs2_reg_val == {DATA_W{1'b0}}) begin
                  result_d    = {DATA_W{1'b1}};
                  result_hi_d = dz_hi_s;
                  carry_d     = 1'b0;
                  dbz_d       = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  rem_d   = {DATA_W{1'b0}};
                  quo_d   = rs1_reg_val;
                  dvsr_d  = rs2_reg_val;
                  cnt_d   = 5'd0;
                  state_d = S_DIV;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_MUL: begin
               acc_d    = mul_sum_s;
               mcand_d  = {mcand_q[AW-2:0], 1'b0};
               mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
               cnt_d    = cnt_q + 5'd1;
               if (cnt_q == LAST_ITER) begin
                  result_d    = mul_sum_s[DATA_W-1:0];
                  result_hi_d = mul_hi_s;
                  carry_d     = 1'b0;
                  dbz_d       = 1'b0;
                  state_d     = S_DONE;
               end else begin
                  state_d = S_MUL;
               end
            end
            S_DIV: begin
               rem_d = rem_next_s;
               quo_d = quo_next_s;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == LAST_ITER) begin
                  result_d    = quo_next_s;
                  result_hi_d = div_hi_s;
                  carry_d     = 1'b0;
                  dbz_d       = 1'b0;
                  state_d     = S_DONE;
               end else begin
                  state_d = S_DIV;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 5'd0;
         mcand_q     <= {AW{1'b0}};
         acc_q       <= {AW{1'b0}};
         mplier_q    <= {DATA_W{1'b0}};
         rem_q       <= {DATA_W{1'b0}};
         quo_q       <= {DATA_W{1'b0}};
         dvsr_q      <= {DATA_W{1'b0}};
         result_q    <= {DATA_W{1'b0}};
         result_hi_q <= {DATA_W{1'b0}};
         carry_q     <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mcand_q     <= mcand_d;
         acc_q       <= acc_d;
         mplier_q    <= mplier_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvsr_q      <= dvsr_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         carry_q     <= carry_d;
         dbz_q       <= dbz_d;
      end
   end

   assign out_valid   = (state_q == S_DONE);
   assign result      = result_q;
   assign result_hi   = result_hi_q;
   assign carry       = carry_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: arithmetic/latency reference model compared every cycle,
// directed vectors with literal expectations, then randomized traffic.
module tb_alu_exec_unit;
   localparam int W = 16;
`ifdef ALU_HI_RESULT_EN
   localparam bit HI = 1'b1;
`else
   localparam bit HI = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [1:0]   op_opcode = 2'd0;
   logic [W-1:0] rs1 = 16'h0, rs2 = 16'h0;
   logic         in_ready, out_valid, carry, div_by_zero;
   logic [W-1:0] result, result_hi;
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.DATA_W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_opcode(op_opcode), .rs1_reg_val(rs1), .rs2_reg_val(rs2),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .result_hi(result_hi), .carry(carry), .div_by_zero(div_by_zero)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a pending result plus a countdown of iteration cycles.
   bit           m_valid = 1'b0;
   int           m_left = 0;
   logic [W-1:0] m_res = 16'h0, m_hi = 16'h0, p_res = 16'h0, p_hi = 16'h0;
   logic         m_carry = 1'b0, m_dbz = 1'b0;

   function automatic bit m_in_ready();
      return !rst && (m_left == 0) && (!m_valid || out_ready);
   endfunction

   always @(posedge clk) begin : model
      bit          take;
      logic [31:0] sum;
      logic [63:0] prod;
      if (rst) begin
         m_valid = 1'b0; m_left = 0; m_res = 16'h0; m_hi = 16'h0; m_carry = 1'b0; m_dbz = 1'b0;
      end else begin
         take = in_valid && m_in_ready();
         if (m_valid && out_ready) m_valid = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_valid = 1'b1; m_res = p_res; m_hi = p_hi; m_carry = 1'b0; m_dbz = 1'b0;
            end
         end
         if (take) begin
            case (op_opcode)
               2'd0: begin
                  sum = 32'(rs1) + 32'(rs2);
                  m_res = sum[15:0]; m_carry = (sum > 32'd65535); m_hi = 16'h0; m_dbz = 1'b0; m_valid = 1'b1;
               end
               2'd1: begin
                  m_res = rs1 - rs2; m_carry = (rs1 < rs2); m_hi = 16'h0; m_dbz = 1'b0; m_valid = 1'b1;
               end
               2'd2: begin
                  prod = 64'(rs1) * 64'(rs2);
                  p_res = prod[15:0]; p_hi = HI ? prod[31:16] : 16'h0; m_left = 16;
               end
               default: begin
                  if (rs2 == 16'h0) begin
                     m_res = 16'hFFFF; m_hi = HI ? rs1 : 16'h0; m_carry = 1'b0; m_dbz = 1'b1; m_valid = 1'b1;
                  end else begin
                     p_res = rs1 / rs2; p_hi = HI ? (rs1 % rs2) : 16'h0; m_left = 16;
                  end
               end
            endcase
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, m_in_ready());
      chk("result", result, m_res);
      chk("result_hi", result_hi, m_hi);
      chk("carry", carry, m_carry);
      chk("div_by_zero", div_by_zero, m_dbz);
   end

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      op_opcode = op; rs1 = a; rs2 = b; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 100) begin
         @(posedge clk); #3; n++;
      end
      if (n >= 100) chk("issue timeout", n, 0);
      @(posedge clk); #2;
      in_valid = 1'b0; rs1 = 16'($urandom); rs2 = 16'($urandom); op_opcode = 2'($urandom);
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #2; cyc++;
      end
      if (!out_valid) chk("out_valid timeout", out_valid, 1);
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk); #2;
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic [W-1:0] held_res, held_hi;
      repeat (3) @(posedge clk);
      #2;
      chk("reset out_valid", out_valid, 0);
      chk("reset result", result, 16'h0);
      rst = 1'b0;
      #1;
      chk("in_ready after reset", in_ready, 1);

      issue(2'd0, 16'hFFFF, 16'h0002); wait_valid(lat);
      chk("add latency", lat, 0); chk("add result", result, 16'h0001); chk("add carry", carry, 1);
      pop();
      issue(2'd1, 16'd5, 16'd7); wait_valid(lat);
      chk("sub result", result, 16'hFFFE); chk("sub borrow", carry, 1);
      pop();
      issue(2'd2, 16'h0123, 16'h0456); wait_valid(lat);
      chk("mul latency", lat, 16); chk("mul result", result, 16'hEDC2);
      chk("mul hi", result_hi, HI ? 16'h0004 : 16'h0000); chk("mul carry", carry, 0);
      pop();
      issue(2'd3, 16'd1000, 16'd7); wait_valid(lat);
      chk("div latency", lat, 16); chk("div result", result, 16'd142);
      chk("div hi", result_hi, HI ? 16'd6 : 16'd0);
      pop();
      issue(2'd3, 16'd9, 16'd0); wait_valid(lat);
      chk("div0 latency", lat, 0); chk("div0 result", result, 16'hFFFF);
      chk("div0 flag", div_by_zero, 1); chk("div0 hi", result_hi, HI ? 16'd9 : 16'd0);
      pop();

      // Result held while writeback stalls; offered ops are refused meanwhile.
      issue(2'd2, 16'h8001, 16'h0003); wait_valid(lat);
      chk("mul2 result", result, 16'h8003);
      held_res = result; held_hi = result_hi;
      in_valid = 1'b1; op_opcode = 2'd1; rs1 = 16'h00AA; rs2 = 16'h0055;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         chk("hold in_ready", in_ready, 0); chk("hold out_valid", out_valid, 1);
         chk("hold result", result, held_res); chk("hold result_hi", result_hi, held_hi);
      end
      op_opcode = 2'd0; rs1 = 16'h1234; rs2 = 16'h1111; out_ready = 1'b1;
      #1;
      chk("done+ready in_ready", in_ready, 1);
      @(posedge clk); #2;
      in_valid = 1'b0; out_ready = 1'b0;
      chk("chained add valid", out_valid, 1); chk("chained add result", result, 16'h2345);
      chk("chained add carry", carry, 0);
      pop();

      // Reset during the eighth divide iteration discards the operation.
      issue(2'd3, 16'd50000, 16'd3);
      repeat (7) begin @(posedge clk); #2; end
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      chk("mid-div reset out_valid", out_valid, 0); chk("mid-div reset result", result, 16'h0);
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #2;
         chk("no stale result", out_valid, 0);
      end
      issue(2'd0, 16'd3, 16'd4); wait_valid(lat);
      chk("post-reset add", result, 16'd7);
      pop();

      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #2;
         rst       = ($urandom_range(0, 199) == 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         op_opcode = 2'($urandom);
         rs1       = 16'($urandom);
         case ($urandom_range(0, 5))
            0:       rs2 = 16'h0;
            1:       rs2 = 16'($urandom_range(1, 15));
            default: rs2 = 16'($urandom);
         endcase
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #2;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
